// File: rtl/mux_pkg.sv
// mux_pkg: shared sizing helpers and defaults for the round-robin stream mux
package mux_pkg;
  localparam int N_CH_DEF = 4;
  localparam int WIDTH_DEF = 4;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef logic [ch_w(N_CH_DEF)-1:0] ch_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin / fixed-priority grant with one-hot and encoded outputs
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            fixed_prio,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx
);
  function automatic int pos(input int k);
    return fixed_prio ? k : (int'(ptr) + k) % N_CH;
  endfunction
  always_comb begin
    grant = '0;
    grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant == '0 && req[pos(k)]) begin
        grant[pos(k)] = 1'b1;
        grant_idx = CH_W'(pos(k));
      end
    end
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N_CH valid/ready streams arbitrated into one registered output stage
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CH_W       = ch_w(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data,
  output logic [N_CH-1:0]            in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [CH_W-1:0]            out_ch,
  input  logic                       out_ready
);
  logic [CH_W-1:0] ptr, grant_idx;
  logic [N_CH-1:0] grant;
  logic load;
  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_arb (
    .req(in_valid), .ptr(ptr), .fixed_prio(FIXED_PRIO), .grant(grant), .grant_idx(grant_idx)
  );
  assign load = !out_valid || out_ready;
  // rst_n gating keeps ready low during reset, when out_valid=0 would otherwise open the stage
  assign in_ready = (load && rst_n) ? grant : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= |in_valid;
      if (|in_valid) begin
        out_data <= in_data[grant_idx];
        out_ch <= grant_idx;
        ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed + random checks of round-robin and fixed-priority instances against a reference model
module tb_rr_stream_mux;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
  logic [3:0] in_valid = '0;
  logic [3:0][3:0] in_data = '0;
  logic [3:0] rdy, rdy_f;
  logic ov, ov_f;
  logic [3:0] od, od_f;
  logic [1:0] oc, oc_f;
  int n_cmp = 0, n_err = 0;
  bit m_valid, f_valid;
  logic [3:0] m_data, f_data;
  int m_ch, f_ch, m_ptr;
  logic [3:0] pend;

  always #5 clk = ~clk;

  rr_stream_mux #(.N_CH(4), .WIDTH(4), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy),
    .out_valid(ov), .out_data(od), .out_ch(oc), .out_ready(out_ready));
  rr_stream_mux #(.N_CH(4), .WIDTH(4), .FIXED_PRIO(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_f),
    .out_valid(ov_f), .out_data(od_f), .out_ch(oc_f), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requester in search order, -1 if none
  function automatic int pick(input logic [3:0] v, input int p, input bit fixed);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = fixed ? k : (p + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_ch = 0; m_ptr = 0;
    f_valid = 0; f_data = '0; f_ch = 0;
  endtask

  task automatic check_out();
    chk("rr_valid", 32'(ov), 32'(m_valid));
    chk("rr_data", 32'(od), 32'(m_data));
    chk("rr_ch", 32'(oc), 32'(m_ch));
    chk("fp_valid", 32'(ov_f), 32'(f_valid));
    chk("fp_data", 32'(od_f), 32'(f_data));
    chk("fp_ch", 32'(oc_f), 32'(f_ch));
  endtask

  // one clock: check ready mid-cycle, advance model on the edge, check outputs just after
  task automatic step();
    int g, gf;
    bit ml, fl;
    #3;
    g = pick(in_valid, m_ptr, 1'b0);
    gf = pick(in_valid, 0, 1'b1);
    ml = !m_valid || out_ready;
    fl = !f_valid || out_ready;
    chk("rr_ready", 32'(rdy), (ml && g >= 0) ? (32'd1 << g) : 32'd0);
    chk("fp_ready", 32'(rdy_f), (fl && gf >= 0) ? (32'd1 << gf) : 32'd0);
    @(posedge clk);
    if (ml) begin
      m_valid = (g >= 0);
      if (g >= 0) begin m_data = in_data[g]; m_ch = g; m_ptr = (g + 1) % 4; end
    end
    if (fl) begin
      f_valid = (gf >= 0);
      if (gf >= 0) begin f_data = in_data[gf]; f_ch = gf; end
    end
    if (g >= 0 && ml) pend[g] = 1'b0;
    #1;
    check_out();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    chk("rst_valid", 32'(ov), 32'd0);
    chk("rst_ch", 32'(oc), 32'd0);
    chk("rst_ready", 32'(rdy | rdy_f), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    pend = '0;
    in_valid = 4'b1111;
    #2;
    chk("reset_valid", 32'(ov), 32'd0);
    chk("reset_data", 32'(od), 32'd0);
    chk("reset_ready", 32'(rdy), 32'd0);
    in_valid = '0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    // single channel
    in_data = {4'hd, 4'hc, 4'hb, 4'ha};
    out_ready = 1'b1;
    in_valid = 4'b0010;
    step();
    chk("t1_data", 32'(od), 32'hb);
    chk("t1_ch", 32'(oc), 32'd1);
    in_valid = '0;
    step();
    // round-robin fairness: reset brings ptr back to 0 first
    pulse_reset();
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t2_ch", 32'(oc), 32'(k % 4));
      chk("t2_valid", 32'(ov), 32'd1);
    end
    // backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_ready", 32'(rdy), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("t3_resume_ch", 32'(oc), 32'd0);
    // fixed priority instance
    in_valid = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_fp_ch", 32'(oc_f), 32'd1);
      chk("t4_fp_data", 32'(od_f), 32'hb);
    end
    // async reset mid-stream
    in_valid = 4'b1111;
    step();
    pulse_reset();
    step();
    chk("t6_first_ch", 32'(oc), 32'd0);
    // X isolation on non-selected channel
    pulse_reset();
    in_data = {4'bxxxx, 4'h3, 4'ha, 4'h7};
    in_valid = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_ch", 32'(oc), 32'(k));
    end
    chk("t5_data", 32'(od), 32'h3);
    in_valid = 4'b1000;
    step();
    chk("t5_xch", 32'(oc), 32'd3);
    // random traffic with requests held until granted
    pend = '0;
    for (int k = 0; k < 300; k++) begin
      pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int c = 0; c < 4; c++) in_data[c] = 4'($urandom);
      in_valid = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the combinational 4:1 mux.
- Selects one of N_CH valid/ready input streams of WIDTH bits and forwards it through a single registered output stage.
- The grant is round-robin, or fixed-priority when FIXED_PRIO=1.
- Used wherever several producers share one consumer; output carries the source channel index.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 4, data width per channel.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = lowest index always wins.
- CH_W, $clog2(N_CH), width of channel index (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N_CH  per-channel valid.
- in_data  input  N_CH x WIDTH  packed array; in_data[i] belongs to channel i.
- in_ready  output  N_CH  per-channel ready; at most one bit high per cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_ch  output  CH_W  channel index of out_data.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, priority pointer ptr=0. All in_ready=0 while rst_n is low.
- load = !out_valid || out_ready. The output stage may take a new beat this cycle.
- Grant, round-robin: the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1 (mod N_CH).
- Grant, fixed-priority (FIXED_PRIO=1): the lowest i with in_valid[i]=1; ptr is ignored.
- in_ready[i] = load && grant[i]. This is combinational from in_valid and out_ready; there is no skid buffer.
- Transfer on channel g: in_valid[g] && in_ready[g]. At the next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1, ptr<=(g+1) mod N_CH.
- load=1 with no in_valid: at the next edge out_valid<=0. out_data and out_ch hold their last values.
- load=0 (out_valid && !out_ready): out_valid, out_data, out_ch and ptr hold. All in_ready=0.
- Latency: input transfer to out_valid is 1 cycle. Sustained throughput is 1 beat/cycle while out_ready=1.
- Simultaneous events: out_ready=1 and a pending request in the same cycle replace the output beat with no bubble.
- Wrap-around: ptr=N_CH-1 and grant to N_CH-1 gives ptr=0.
- Requests hold: a requester not granted keeps in_valid high. It waits at most N_CH-1 grants in round-robin mode; no starvation guarantee in fixed-priority mode.
- in_data of a non-granted channel is don't-care, including X. X on a non-selected channel must not propagate to out_data.
- Reset mid-operation: a held beat is dropped, out_valid=0 immediately, ptr returns to 0.
- The block does not check in_valid being withdrawn without a transfer; the upstream must hold it.

Decomposition:
- Package mux_pkg:
  - function ch_w(n), returning $clog2 with a minimum of 1;
  - localparam defaults for N_CH and WIDTH;
  - typedef for the channel index.
- Sub-module rr_arbiter: purely combinational. Inputs: req[N_CH], ptr[CH_W], fixed_prio. Outputs: one-hot grant and encoded grant index.
- rr_stream_mux contains ptr, the output register and the data select, which is indexed by the encoded grant.

Test Plan (N_CH=4, WIDTH=4, FIXED_PRIO=0 unless stated):
1. Reset then single channel: in_valid=0010, in_data={d,c,b,a}, out_ready=1 -> in_ready=0010; next cycle out_valid=1, out_data='hb, out_ch=1; ptr becomes 2.
2. Round-robin fairness: in_valid=1111 held, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_data a,b,c,d,a,b,c,d; no bubbles.
3. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=0000. out_ready=1 -> the next-priority channel is accepted in the same cycle.
4. Fixed priority: FIXED_PRIO=1, in_valid=1110 held -> out_ch stays 1 every cycle, out_data='hb.
5. X isolation: in_data={x,3,'ha,7}, in_valid=0111 -> out_data 7,'ha,3 (ch 0,1,2), never X. in_valid=1000 -> out_data x, out_ch=3.
6. Async reset mid-stream: drop rst_n between clock edges while out_valid=1 -> out_valid=0 and out_ch=0 immediately. After release, in_valid=1111 -> first grant is ch 0.
